// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a fetch port and a data port share one RAM.
// Simultaneous requests are granted round-robin. Each access holds the RAM
// address for WAIT cycles, then pulses the granted port's ack for one cycle.
// The RAM read data is asynchronous and is captured into a registered rdata.
module mem_arbiter #(
  parameter int WAIT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic        busy,
  output logic [15:0] Ma,
  output logic [15:0] Mwd,
  output logic        Mwen,
  input  logic [15:0] Mrd
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [3:0]  cnt;
  logic        last_grant;
  logic        cur_d;
  logic        cur_we;
  logic        grant_any;
  logic        grant_d;

  // Arbitration: a lone requester wins; on a tie, the port not granted last time wins.
  always_comb begin
    grant_any = f_req | d_req;
    grant_d   = d_req & (~f_req | ~last_grant);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state logic: IDLE until a request, ACCESS until the wait counter expires, one HOLD cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (grant_any) next_state = ACCESS;
      ACCESS:  if (cnt == 4'd0) next_state = HOLD;
      HOLD:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: grant capture, wait countdown, read-data capture and ack pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= 4'd0;
      last_grant <= 1'b0;
      cur_d      <= 1'b0;
      cur_we     <= 1'b0;
      Ma         <= 16'h0000;
      Mwd        <= 16'h0000;
      Mwen       <= 1'b0;
      f_ack      <= 1'b0;
      d_ack      <= 1'b0;
      f_rdata    <= 16'h0000;
      d_rdata    <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            cnt        <= 4'(WAIT - 1);
            last_grant <= grant_d;
            cur_d      <= grant_d;
            cur_we     <= grant_d & d_we;
            Ma         <= grant_d ? d_addr : f_addr;
            if (grant_d && d_we) begin
              Mwd  <= d_wdata;
              Mwen <= 1'b1;
            end else begin
              Mwd  <= 16'h0000;
              Mwen <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            Mwen <= 1'b0;
            if (cur_d) begin
              d_ack <= 1'b1;
              if (!cur_we) d_rdata <= Mrd;
            end else begin
              f_ack   <= 1'b1;
              f_rdata <= Mrd;
            end
          end
        end
        HOLD: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
          Ma    <= 16'h0000;
          Mwd   <= 16'h0000;
          Mwen  <= 1'b0;
        end
        default: begin
          f_ack <= 1'b0;
          d_ack <= 1'b0;
        end
      endcase
    end
  end

  // Busy whenever an access is in flight.
  always_comb begin
    busy = (state != IDLE);
  end

endmodule
